cache_arbiter: RTL
==================

Name: cache_arbiter

Overview:
- Shares the single 256-bit physical-memory port between the instruction cache and the data cache.
- Each cache presents a line-granular pmem request. The arbiter grants one cache at a time, latches that cache's command, and drives it to memory until pmem_resp. It then routes the response back to the owner only.
- Sits between the two caches and the cacheline adapter / main-memory model.

Parameters:
s_line, 256, cacheline width in bits (pmem data width)
s_addr, 32, address width
RR_EN, 1, 1 = round-robin on simultaneous requests; 0 = fixed dcache priority

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
i_pmem_address  input  s_addr  icache line address
i_pmem_read  input  1  icache fill request, held until i_pmem_resp
i_pmem_rdata  output  s_line  line data to icache
i_pmem_resp  output  1  icache transaction complete
d_pmem_address  input  s_addr  dcache line address
d_pmem_read  input  1  dcache fill request, held until d_pmem_resp
d_pmem_write  input  1  dcache write-back request, held until d_pmem_resp
d_pmem_wdata  input  s_line  dcache write-back line
d_pmem_rdata  output  s_line  line data to dcache
d_pmem_resp  output  1  dcache transaction complete
pmem_address  output  s_addr  to memory, registered
pmem_read  output  1  to memory, registered
pmem_write  output  1  to memory, registered
pmem_wdata  output  s_line  to memory, registered
pmem_rdata  input  s_line  from memory
pmem_resp  input  1  from memory, one-cycle pulse per transaction

Behaviour:
- States: ARB_IDLE, ARB_ICACHE, ARB_DCACHE. A last_grant bit records the most recent owner.
- Reset (rst low, async):
  - state = ARB_IDLE; last_grant = ICACHE, so dcache wins the first tie.
  - pmem_read/pmem_write = 0; pmem_address/pmem_wdata = 0.
  - i_pmem_resp/d_pmem_resp = 0.
  - Reset mid-transaction abandons it silently; memory is assumed to be reset concurrently.
- ARB_IDLE:
  - Sample requests. Request valid: icache = i_pmem_read; dcache = d_pmem_read | d_pmem_write.
  - One requester: grant it.
  - Both requesters:
    - RR_EN=1: grant the requester that is not last_grant.
    - RR_EN=0: always grant dcache.
  - On grant, on the same edge:
    - Latch address, op and wdata into the pmem_* registers.
    - Move to the owner state and update last_grant.
  - dcache op resolution: d_pmem_write=1 -> write (wins if read is also asserted, a protocol violation); otherwise read.
  - Latency: request visible at edge N -> pmem_read/pmem_write high from N+1.
- ARB_ICACHE / ARB_DCACHE:
  - Hold the pmem_* registers constant; requester inputs are not resampled.
  - On pmem_resp=1, combinationally in the same cycle:
    - Assert the owner's *_pmem_resp.
    - Drop pmem_read/pmem_write at the next edge and return to ARB_IDLE.
  - Non-owner resp stays 0.
- Read data:
  - i_pmem_rdata and d_pmem_rdata are both wired directly to pmem_rdata.
  - Each is meaningful only with its own resp.
- Timing and edge cases:
  - Turnaround: one ARB_IDLE cycle is mandatory between transactions; the earliest next grant is the edge after resp.
  - A requester still asserting in that IDLE cycle is treated as a new request. Caches must drop their request the cycle after resp unless they really want another line.
  - A dcache write-back followed by its fill is two transactions. With RR_EN=1 and icache waiting, an icache fill is interleaved between them. This is legal.
  - pmem_resp while in ARB_IDLE is ignored: no resp is generated and no state changes.
  - A requester dropping its request mid-transaction does not cancel it. The transaction completes and resp is still pulsed.
- Starvation: with RR_EN=1, neither requester waits more than one transaction when both request continuously.

Decomposition:
- Package cache_arb_pkg holds:
  - typedef enum arb_state_t {ARB_IDLE, ARB_ICACHE, ARB_DCACHE}
  - typedef enum logic {REQ_ICACHE, REQ_DCACHE} arb_req_t
  - localparam line width
- One sub-module, arb_rr_pick: combinational 2-way selector.
  - Inputs: req_i, req_d, last_grant, rr_en.
  - Outputs: grant_valid, grant_id.
- The top holds the FSM, the command registers and the response steering.

Test Plan:
- Reset then icache read addr 0x0000_1000; memory resp after 5 cycles with 0xA5..A5 -> pmem_read high from cycle+1 with pmem_address=0x1000. i_pmem_resp pulses once with i_pmem_rdata=0xA5..A5. d_pmem_resp stays 0.
- dcache write addr 0x0000_2020 with wdata=0x1234..; resp after 3 cycles -> pmem_write=1, pmem_wdata=0x1234.., pmem_read=0. d_pmem_resp pulses once, then pmem_write=0.
- After reset, icache and dcache request the same cycle, RR_EN=1 -> dcache granted first. After its resp plus one IDLE cycle, icache is granted. Repeat with both held continuously -> grants alternate D,I,D,I.
- RR_EN=0, both requesting continuously for 4 transactions -> all 4 granted to dcache; icache waits.
- Spurious pmem_resp in ARB_IDLE -> no *_resp, state remains ARB_IDLE. Assert rst low mid ARB_DCACHE -> pmem_write=0 immediately (async) and state=ARB_IDLE.
- dcache asserts read and write together at addr 0x40 -> treated as write (pmem_write=1, pmem_read=0).

Source files
------------

// File: rtl/cache_arb_pkg.sv
// Shared types and widths for the icache/dcache physical-memory arbiter.
package cache_arb_pkg;

   localparam int unsigned LINE_W = 256;
   localparam int unsigned ADDR_W = 32;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_ICACHE,
      ARB_DCACHE
   } arb_state_t;

   typedef enum logic {
      REQ_ICACHE,
      REQ_DCACHE
   } arb_req_t;

endpackage

// File: rtl/cache_arbiter_if.sv
// Bundle of the icache, dcache and main-memory pmem signals around the arbiter.
// master = caches plus memory model, slave = the arbiter itself.
interface cache_arbiter_if
   import cache_arb_pkg::*;
#(
   parameter int unsigned s_line = LINE_W,
   parameter int unsigned s_addr = ADDR_W
);

   // icache side
   logic [s_addr-1:0] i_pmem_address;
   logic              i_pmem_read;
   logic [s_line-1:0] i_pmem_rdata;
   logic              i_pmem_resp;

   // dcache side
   logic [s_addr-1:0] d_pmem_address;
   logic              d_pmem_read;
   logic              d_pmem_write;
   logic [s_line-1:0] d_pmem_wdata;
   logic [s_line-1:0] d_pmem_rdata;
   logic              d_pmem_resp;

   // memory side
   logic [s_addr-1:0] pmem_address;
   logic              pmem_read;
   logic              pmem_write;
   logic [s_line-1:0] pmem_wdata;
   logic [s_line-1:0] pmem_rdata;
   logic              pmem_resp;

   modport master (
      output i_pmem_address, i_pmem_read,
      input  i_pmem_rdata, i_pmem_resp,
      output d_pmem_address, d_pmem_read, d_pmem_write, d_pmem_wdata,
      input  d_pmem_rdata, d_pmem_resp,
      input  pmem_address, pmem_read, pmem_write, pmem_wdata,
      output pmem_rdata, pmem_resp
   );

   modport slave (
      input  i_pmem_address, i_pmem_read,
      output i_pmem_rdata, i_pmem_resp,
      input  d_pmem_address, d_pmem_read, d_pmem_write, d_pmem_wdata,
      output d_pmem_rdata, d_pmem_resp,
      output pmem_address, pmem_read, pmem_write, pmem_wdata,
      input  pmem_rdata, pmem_resp
   );

endinterface

// File: rtl/arb_rr_pick.sv
// Combinational 2-way requester selector: round-robin on ties when rr_en,
// otherwise dcache always wins a tie.
module arb_rr_pick
   import cache_arb_pkg::*;
(
   input  logic     req_i,
   input  logic     req_d,
   input  arb_req_t last_grant,
   input  logic     rr_en,
   output logic     grant_valid,
   output arb_req_t grant_id
);

   // pick the winner among the active requesters
   always_comb begin
      grant_valid = req_i | req_d;
      grant_id    = REQ_DCACHE;
      if (req_i && req_d) begin
         if (rr_en) begin
            grant_id = (last_grant == REQ_ICACHE) ? REQ_DCACHE : REQ_ICACHE;
         end
      end else if (req_i) begin
         grant_id = REQ_ICACHE;
      end
   end

endmodule

// File: rtl/cache_arbiter.sv
// Shares one line-wide pmem port between icache and dcache. A granted command
// is latched into the pmem registers and held until pmem_resp, which is then
// steered combinationally back to the owning cache only.
module cache_arbiter
   import cache_arb_pkg::*;
#(
   parameter int unsigned s_line = LINE_W,
   parameter int unsigned s_addr = ADDR_W,
   parameter bit          RR_EN  = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   cache_arbiter_if.slave bus
);

   arb_state_t        r_state;
   arb_state_t        w_next_state;
   arb_req_t          r_last_grant;
   logic [s_addr-1:0] r_pmem_address;
   logic              r_pmem_read;
   logic              r_pmem_write;
   logic [s_line-1:0] r_pmem_wdata;

   logic              w_req_i;
   logic              w_req_d;
   logic              w_grant_valid;
   arb_req_t          w_grant_id;
   logic              w_i_resp;
   logic              w_d_resp;

   assign w_req_i = bus.i_pmem_read;
   assign w_req_d = bus.d_pmem_read | bus.d_pmem_write;

   arb_rr_pick u_pick (
      .req_i       (w_req_i),
      .req_d       (w_req_d),
      .last_grant  (r_last_grant),
      .rr_en       (RR_EN),
      .grant_valid (w_grant_valid),
      .grant_id    (w_grant_id)
   );

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ARB_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // next-state: grant from idle, return to idle on the memory response
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ARB_IDLE: begin
            if (w_grant_valid) begin
               w_next_state = (w_grant_id == REQ_DCACHE) ? ARB_DCACHE : ARB_ICACHE;
            end
         end
         ARB_ICACHE, ARB_DCACHE: begin
            if (bus.pmem_resp) w_next_state = ARB_IDLE;
         end
         default: w_next_state = ARB_IDLE;
      endcase
   end

   // command registers and last owner; loaded only on a grant from idle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_last_grant   <= REQ_ICACHE;
         r_pmem_address <= '0;
         r_pmem_read    <= 1'b0;
         r_pmem_write   <= 1'b0;
         r_pmem_wdata   <= '0;
      end else begin
         case (r_state)
            ARB_IDLE: begin
               if (w_grant_valid) begin
                  r_last_grant <= w_grant_id;
                  if (w_grant_id == REQ_DCACHE) begin
                     // write wins if both are asserted
                     r_pmem_address <= bus.d_pmem_address;
                     r_pmem_write   <= bus.d_pmem_write;
                     r_pmem_read    <= ~bus.d_pmem_write;
                     r_pmem_wdata   <= bus.d_pmem_wdata;
                  end else begin
                     r_pmem_address <= bus.i_pmem_address;
                     r_pmem_write   <= 1'b0;
                     r_pmem_read    <= 1'b1;
                     r_pmem_wdata   <= '0;
                  end
               end
            end
            ARB_ICACHE, ARB_DCACHE: begin
               if (bus.pmem_resp) begin
                  r_pmem_read  <= 1'b0;
                  r_pmem_write <= 1'b0;
               end
            end
            default: begin
               r_pmem_read  <= 1'b0;
               r_pmem_write <= 1'b0;
            end
         endcase
      end
   end

   // response steering: only the current owner sees pmem_resp
   always_comb begin
      w_i_resp = 1'b0;
      w_d_resp = 1'b0;
      case (r_state)
         ARB_ICACHE: w_i_resp = bus.pmem_resp;
         ARB_DCACHE: w_d_resp = bus.pmem_resp;
         default: ;
      endcase
   end

   assign bus.i_pmem_resp  = w_i_resp;
   assign bus.d_pmem_resp  = w_d_resp;
   assign bus.i_pmem_rdata = bus.pmem_rdata;
   assign bus.d_pmem_rdata = bus.pmem_rdata;
   assign bus.pmem_address = r_pmem_address;
   assign bus.pmem_read    = r_pmem_read;
   assign bus.pmem_write   = r_pmem_write;
   assign bus.pmem_wdata   = r_pmem_wdata;

endmodule
